// File: rtl/libalu_pkg.sv
// Shared ALU/branch definitions: compare codes, branch funct3 values, resolve-state enum.
package libalu;

    localparam logic [1:0] BRAN_GT  = 2'd0;
    localparam logic [1:0] BRAN_LT  = 2'd1;
    localparam logic [1:0] BRAN_EQ  = 2'd2;
    localparam logic [1:0] BRAN_ERR = 2'd3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } resolve_state_t;

endpackage

// File: rtl/branch_taken_decode.sv
// Combinational mapping of funct3 + compare codes (+ jump) to taken/err.
module branch_taken_decode
    import libalu::*;
(
    input  logic       is_jump,
    input  logic [2:0] funct3,
    input  logic [1:0] code_s,
    input  logic [1:0] code_u,
    output logic       taken,
    output logic       err
);

    logic [1:0] sel;

    // Select the relevant compare code and evaluate the branch condition.
    always_comb begin
        taken = 1'b0;
        err   = 1'b0;
        sel   = code_s;
        if (is_jump) begin
            taken = 1'b1;
        end else begin
            case (funct3)
                F3_BEQ:  taken = (code_s == BRAN_EQ);
                F3_BNE:  taken = (code_s != BRAN_EQ);
                F3_BLT:  taken = (code_s == BRAN_LT);
                F3_BGE:  taken = (code_s == BRAN_GT) || (code_s == BRAN_EQ);
                F3_BLTU: begin
                    sel   = code_u;
                    taken = (code_u == BRAN_LT);
                end
                F3_BGEU: begin
                    sel   = code_u;
                    taken = (code_u == BRAN_GT) || (code_u == BRAN_EQ);
                end
                default: err = 1'b1;
            endcase
            if (sel == BRAN_ERR) begin
                err = 1'b1;
            end
            if (err) begin
                taken = 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves branch outcomes, issues redirect to fetch, flushes the pipeline, counts branches.
module branch_resolve
    import libalu::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid_i,
    output logic             br_ready_o,
    input  logic             br_is_jump_i,
    input  logic [2:0]       br_funct3_i,
    input  logic [1:0]       rs1_rs2_eqz_i,
    input  logic [1:0]       rs1_rs2_eqz_u_i,
    input  logic [XLEN-1:0]  br_pc_i,
    input  logic [XLEN-1:0]  br_target_i,
    input  logic             br_pred_taken_i,
    output logic             redir_valid_o,
    input  logic             redir_ready_i,
    output logic [XLEN-1:0]  redir_pc_o,
    output logic             flush_o,
    output logic             br_err_o,
    output logic [CNT_W-1:0] cnt_branch_o,
    output logic [CNT_W-1:0] cnt_mispred_o
);

    localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    resolve_state_t  state;
    logic [FCW-1:0]  flush_cnt;
    logic            dec_taken;
    logic            dec_err;
    logic            mispred;
    logic [XLEN-1:0] actual_pc;

    branch_taken_decode u_decode (
        .is_jump (br_is_jump_i),
        .funct3  (br_funct3_i),
        .code_s  (rs1_rs2_eqz_i),
        .code_u  (rs1_rs2_eqz_u_i),
        .taken   (dec_taken),
        .err     (dec_err)
    );

    assign mispred    = dec_taken ^ br_pred_taken_i;
    assign actual_pc  = dec_taken ? br_target_i : br_pc_i + XLEN'(4);
    assign br_ready_o = (state == ST_IDLE);

    // Resolve FSM with registered redirect/flush/error outputs and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            flush_cnt     <= '0;
            redir_valid_o <= 1'b0;
            redir_pc_o    <= '0;
            flush_o       <= 1'b0;
            br_err_o      <= 1'b0;
            cnt_branch_o  <= '0;
            cnt_mispred_o <= '0;
        end else begin
            br_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (br_valid_i) begin
                        if (dec_err) begin
                            br_err_o <= 1'b1;
                        end else begin
                            if (cnt_branch_o != '1) begin
                                cnt_branch_o <= cnt_branch_o + CNT_W'(1);
                            end
                            if (mispred) begin
                                if (cnt_mispred_o != '1) begin
                                    cnt_mispred_o <= cnt_mispred_o + CNT_W'(1);
                                end
                                state         <= ST_REDIRECT;
                                redir_valid_o <= 1'b1;
                                flush_o       <= 1'b1;
                                redir_pc_o    <= actual_pc;
                            end
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (redir_ready_i) begin
                        state         <= ST_FLUSH;
                        redir_valid_o <= 1'b0;
                        flush_cnt     <= FLUSH_LOAD;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= ST_IDLE;
                        flush_o <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FCW'(1);
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    redir_valid_o <= 1'b0;
                    flush_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve against an operand-level reference model.
module tb_branch_resolve;

    localparam int unsigned XLEN = 32;
    localparam int unsigned FC   = 2;
    localparam int unsigned CW   = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            br_valid_i;
    logic            br_ready_o;
    logic            br_is_jump_i;
    logic [2:0]      br_funct3_i;
    logic [1:0]      rs1_rs2_eqz_i;
    logic [1:0]      rs1_rs2_eqz_u_i;
    logic [XLEN-1:0] br_pc_i;
    logic [XLEN-1:0] br_target_i;
    logic            br_pred_taken_i;
    logic            redir_valid_o;
    logic            redir_ready_i;
    logic [XLEN-1:0] redir_pc_o;
    logic            flush_o;
    logic            br_err_o;
    logic [CW-1:0]   cnt_branch_o;
    logic [CW-1:0]   cnt_mispred_o;

    int n_pass  = 0;
    int n_total = 0;
    int m_br    = 0;
    int m_mis   = 0;

    branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .br_valid_i      (br_valid_i),
        .br_ready_o      (br_ready_o),
        .br_is_jump_i    (br_is_jump_i),
        .br_funct3_i     (br_funct3_i),
        .rs1_rs2_eqz_i   (rs1_rs2_eqz_i),
        .rs1_rs2_eqz_u_i (rs1_rs2_eqz_u_i),
        .br_pc_i         (br_pc_i),
        .br_target_i     (br_target_i),
        .br_pred_taken_i (br_pred_taken_i),
        .redir_valid_o   (redir_valid_o),
        .redir_ready_i   (redir_ready_i),
        .redir_pc_o      (redir_pc_o),
        .flush_o         (flush_o),
        .br_err_o        (br_err_o),
        .cnt_branch_o    (cnt_branch_o),
        .cnt_mispred_o   (cnt_mispred_o)
    );

    always #5 clk = ~clk;

    // Comparator stand-in: derive compare codes from raw operand values.
    function automatic logic [1:0] code_of(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        if (a == b) return 2'd2;
        if (sgn) return ($signed(a) < $signed(b)) ? 2'd1 : 2'd0;
        return (a < b) ? 2'd1 : 2'd0;
    endfunction

    // Architectural branch condition evaluated directly on operands.
    function automatic logic ref_taken(input logic jmp, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
        if (jmp) return 1'b1;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset();
        n_total++;
        if ({redir_valid_o, flush_o, br_ready_o, br_err_o} !== 4'b0010)
            $display("FAIL reset_ctrl got %b exp 0010", {redir_valid_o, flush_o, br_ready_o, br_err_o});
        else n_pass++;
        n_total++;
        if ({redir_pc_o, cnt_branch_o, cnt_mispred_o} !== 96'd0)
            $display("FAIL reset_data pc=%h br=%0d mis=%0d exp all 0", redir_pc_o, cnt_branch_o, cnt_mispred_o);
        else n_pass++;
    endtask

    // Issue one branch and follow it through its full redirect/flush sequence.
    task automatic run_branch(input logic jmp, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic [31:0] tgt, input logic pred,
                              input logic inj_err, input int stall);
        logic        e_tk, e_err, e_mis;
        logic [31:0] e_pc;
        e_err = !jmp && (f3 == 3'd2 || f3 == 3'd3 || inj_err);
        e_tk  = e_err ? 1'b0 : ref_taken(jmp, f3, a, b);
        e_mis = !e_err && (e_tk != pred);
        e_pc  = e_tk ? tgt : pc + 32'd4;
        @(negedge clk);
        n_total++;
        if (br_ready_o !== 1'b1) $display("FAIL ready_before_accept got %b exp 1", br_ready_o);
        else n_pass++;
        br_valid_i      = 1'b1;
        br_is_jump_i    = jmp;
        br_funct3_i     = f3;
        rs1_rs2_eqz_i   = inj_err ? 2'd3 : code_of(a, b, 1'b1);
        rs1_rs2_eqz_u_i = inj_err ? 2'd3 : code_of(a, b, 1'b0);
        br_pc_i         = pc;
        br_target_i     = tgt;
        br_pred_taken_i = pred;
        redir_ready_i   = 1'($urandom_range(0, 1));
        @(negedge clk);
        br_valid_i = 1'b0;
        if (!e_err) m_br++;
        if (e_mis) m_mis++;
        n_total++;
        if ({br_err_o, redir_valid_o} !== {e_err, e_mis})
            $display("FAIL decision f3=%0d err/redir got %b exp %b", f3, {br_err_o, redir_valid_o}, {e_err, e_mis});
        else n_pass++;
        n_total++;
        if (cnt_branch_o !== CW'(m_br) || cnt_mispred_o !== CW'(m_mis))
            $display("FAIL counters got %0d/%0d exp %0d/%0d", cnt_branch_o, cnt_mispred_o, m_br, m_mis);
        else n_pass++;
        if (e_err) begin
            @(negedge clk);
            n_total++;
            if ({br_err_o, redir_valid_o, br_ready_o} !== 3'b001)
                $display("FAIL err_pulse_end got %b exp 001", {br_err_o, redir_valid_o, br_ready_o});
            else n_pass++;
        end else if (!e_mis) begin
            n_total++;
            if ({redir_valid_o, flush_o, br_ready_o} !== 3'b001)
                $display("FAIL correct_pred got %b exp 001", {redir_valid_o, flush_o, br_ready_o});
            else n_pass++;
        end else begin
            for (int i = 0; i <= stall; i++) begin
                if (i > 0) @(negedge clk);
                n_total++;
                if ({redir_valid_o, flush_o, br_ready_o} !== 3'b110 || redir_pc_o !== e_pc)
                    $display("FAIL redirect cyc=%0d got %b pc=%h exp 110 pc=%h", i,
                             {redir_valid_o, flush_o, br_ready_o}, redir_pc_o, e_pc);
                else n_pass++;
                redir_ready_i = (i == stall);
                br_valid_i    = (i < stall);
            end
            br_valid_i = 1'b0;
            for (int j = 0; j < int'(FC); j++) begin
                @(negedge clk);
                redir_ready_i = 1'b0;
                n_total++;
                if ({redir_valid_o, flush_o, br_ready_o} !== 3'b010)
                    $display("FAIL flush cyc=%0d got %b exp 010", j, {redir_valid_o, flush_o, br_ready_o});
                else n_pass++;
            end
            @(negedge clk);
            n_total++;
            if ({redir_valid_o, flush_o, br_ready_o} !== 3'b001 ||
                cnt_branch_o !== CW'(m_br) || cnt_mispred_o !== CW'(m_mis))
                $display("FAIL back_to_idle got %b cnt %0d/%0d exp 001 cnt %0d/%0d",
                         {redir_valid_o, flush_o, br_ready_o}, cnt_branch_o, cnt_mispred_o, m_br, m_mis);
            else n_pass++;
        end
    endtask

    task automatic test_directed();
        run_branch(1'b0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h200, 1'b0, 1'b0, 0);
        run_branch(1'b0, 3'd6, 32'd1, 32'h8000_0000, 32'h300, 32'h400, 1'b0, 1'b0, 0);
        run_branch(1'b0, 3'd4, 32'd1, 32'h8000_0000, 32'h300, 32'h400, 1'b0, 1'b0, 0);
        run_branch(1'b0, 3'd1, 32'd7, 32'd7, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b0, 0);
        run_branch(1'b0, 3'd0, 32'd3, 32'd3, 32'h500, 32'h600, 1'b0, 1'b0, 3);
    endtask

    task automatic test_errors();
        run_branch(1'b0, 3'd2, 32'd1, 32'd1, 32'h700, 32'h800, 1'b0, 1'b0, 0);
        run_branch(1'b0, 3'd0, 32'd1, 32'd1, 32'h700, 32'h800, 1'b0, 1'b1, 0);
        run_branch(1'b1, 3'd3, 32'd1, 32'd2, 32'h700, 32'h800, 1'b0, 1'b1, 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
            run_branch(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)), a, b,
                       {30'($urandom), 2'b00}, {30'($urandom), 2'b00}, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            logic [31:0] a, b;
            logic [2:0]  f3;
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 0) ? a : 32'($urandom);
            f3 = 3'($urandom_range(0, 7));
            if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd5;
            br_valid_i      = 1'b1;
            br_is_jump_i    = 1'b0;
            br_funct3_i     = f3;
            rs1_rs2_eqz_i   = code_of(a, b, 1'b1);
            rs1_rs2_eqz_u_i = code_of(a, b, 1'b0);
            br_pred_taken_i = ref_taken(1'b0, f3, a, b);
            @(negedge clk);
            m_br++;
            n_total++;
            if (cnt_branch_o !== CW'(m_br) || redir_valid_o !== 1'b0 || br_ready_o !== 1'b1)
                $display("FAIL back_to_back k=%0d cnt=%0d rv=%b rdy=%b exp cnt=%0d rv=0 rdy=1",
                         k, cnt_branch_o, redir_valid_o, br_ready_o, m_br);
            else n_pass++;
        end
        br_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        br_valid_i      = 1'b1;
        br_is_jump_i    = 1'b1;
        br_pred_taken_i = 1'b0;
        br_target_i     = 32'h900;
        redir_ready_i   = 1'b1;
        @(negedge clk);
        br_valid_i = 1'b0;
        @(negedge clk);
        n_total++;
        if ({redir_valid_o, flush_o, br_ready_o} !== 3'b010)
            $display("FAIL pre_reset_flush got %b exp 010", {redir_valid_o, flush_o, br_ready_o});
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        redir_ready_i = 1'b0;
        m_br          = 0;
        m_mis         = 0;
        test_reset();
    endtask

    initial begin
        rst             = 1'b1;
        br_valid_i      = 1'b0;
        br_is_jump_i    = 1'b0;
        br_funct3_i     = 3'd0;
        rs1_rs2_eqz_i   = 2'd0;
        rs1_rs2_eqz_u_i = 2'd0;
        br_pc_i         = '0;
        br_target_i     = '0;
        br_pred_taken_i = 1'b0;
        redir_ready_i   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_directed();
        test_errors();
        test_random();
        test_back_to_back();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Consumes the 2-bit signed/unsigned compare codes produced by the execute-stage branch comparator, together with the branch funct3 and the fetch-stage prediction. It decides the actual branch outcome, detects mispredictions and drives a held redirect handshake to fetch. It then asserts a multi-cycle pipeline flush and maintains saturating branch and mispredict counters. It sits between execute and the fetch/PC-select logic.

## Interface
- XLEN, 32, PC/target width.
- FLUSH_CYCLES, 2, cycles of flush after redirect handshake; legal range ≥1.
- CNT_W, 32, width of the performance counters.

- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- br_valid_i  in  1  execute presents a conditional branch or jump.
- br_ready_o  out  1  block can accept a branch this cycle.
- br_is_jump_i  in  1  unconditional (JAL/JALR): always taken, compare codes ignored.
- br_funct3_i  in  3  RV32 branch funct3.
- rs1_rs2_eqz_i  in  2  signed compare code: 0 GT, 1 LT, 2 EQ, 3 error.
- rs1_rs2_eqz_u_i  in  2  unsigned compare code, same encoding.
- br_pc_i  in  XLEN  PC of the branch.
- br_target_i  in  XLEN  taken target.
- br_pred_taken_i  in  1  prediction fetch used for this branch.
- redir_valid_o  out  1  redirect request to fetch.
- redir_ready_i  in  1  fetch accepts the redirect.
- redir_pc_o  out  XLEN  corrected PC.
- flush_o  out  1  squash younger instructions in IF/ID/EX.
- br_err_o  out  1  one-cycle pulse: illegal funct3 or compare code 3.
- cnt_branch_o  out  CNT_W  resolved branches, saturating.
- cnt_mispred_o  out  CNT_W  mispredicted branches, saturating.

## Operation
- Accept occurs when br_valid_i & br_ready_o; br_ready_o = 1 only in IDLE.
- Taken decision (conditional):
  - BEQ 000: EQ. BNE 001: not EQ.
  - BLT 100: signed LT. BGE 101: signed GT or EQ.
  - BLTU 110: unsigned LT. BGEU 111: unsigned GT or EQ.
  - The selected code equal to 3, or funct3 010/011, is an error.
- Error branch:
  - br_err_o pulses at T+1.
  - No redirect is issued and no counter increments.
  - The block stays in IDLE.
- actual_pc = taken ? br_target_i : br_pc_i + 4. Addition is modulo 2^XLEN; wrap at 0xFFFFFFFC gives 0.
- mispredict = taken XOR br_pred_taken_i.
- States: IDLE, REDIRECT, FLUSH.
  - IDLE to REDIRECT on accept with mispredict; actual_pc is latched into redir_pc_o.
  - IDLE to IDLE on accept with a correct prediction.
  - REDIRECT to FLUSH on redir_valid_o & redir_ready_i; the flush counter loads FLUSH_CYCLES-1.
  - FLUSH counts down and returns to IDLE when the counter is 0.
- redir_valid_o = 1 exactly in REDIRECT. redir_pc_o is stable while redir_valid_o is high.
- flush_o = 1 in REDIRECT and FLUSH.
- Counters (registered, saturating at all-ones):
  - cnt_branch_o increments on every non-error accept.
  - cnt_mispred_o additionally increments when the branch mispredicts.
- Reset: state IDLE, br_ready_o 1, redir_valid_o 0, redir_pc_o 0, flush_o 0, br_err_o 0, both counters 0.
- Reset asserted in REDIRECT or FLUSH aborts the sequence: the next cycle is IDLE with all outputs at reset values.
- br_valid_i while br_ready_o = 0 is ignored. Execute must hold the branch until it is accepted.

## Timing
- Accept at cycle T. Decision and counter updates are visible at T+1.
- Mispredict:
  - redir_valid_o and flush_o are high from T+1.
  - If redir_ready_i = 1 at T+1, FLUSH covers T+2 .. T+1+FLUSH_CYCLES.
  - br_ready_o returns high at T+2+FLUSH_CYCLES.
  - Each cycle redir_ready_i is low extends REDIRECT by one cycle.
- Correct prediction: br_ready_o stays high, so branches can be accepted every cycle.
- Outputs are register-driven, except br_ready_o, which is decoded from state.

## Structure
- Shared package libalu holds:
  - the compare-code constants BRAN_GT = 0, BRAN_LT = 1, BRAN_EQ = 2, BRAN_ERR = 3;
  - the funct3 branch constants;
  - the resolve-state enum.
- One sub-module, branch_taken_decode: combinational mapping of {funct3, both codes, is_jump} to {taken, err}. It is reusable by a future early-resolve path.
- The FSM, flush counter ($clog2(FLUSH_CYCLES+1) bits) and the two performance counters live in the top module.

## Test plan
- BEQ, codes EQ/EQ, pred_taken 0, pc 0x100, target 0x200, ready 1:
  - redir_valid_o and flush_o at T+1 with redir_pc_o 0x200.
  - flush_o high through T+3; br_ready_o high at T+4 (FLUSH_CYCLES = 2).
  - cnt_mispred_o = 1.
- BLTU with signed GT, unsigned LT (rs1 = 1, rs2 = 0x80000000), pred 0:
  - taken, redirect to target.
  - The same inputs with BLT give not taken and no redirect.
- BNE not taken, pred 1, pc 0xFFFFFFFC: redir_pc_o = 0x00000000.
- Mispredict with redir_ready_i low for 3 cycles:
  - redir_valid_o held 4 cycles with a stable PC.
  - A br_valid_i asserted during this time is not accepted.
- funct3 = 010, and separately BEQ with code 3: br_err_o pulses for one cycle, no redirect, counters unchanged.
- Reset asserted mid-FLUSH: the next cycle is IDLE, all outputs are 0 except br_ready_o = 1, and the counters are cleared.
